// File: rtl/mult_seq_sched8.sv
// Iterative unsigned W x W multiplier that time-shares one external H x H core.
// Four partial products are issued one per cycle and accumulated into a 2W result.
module mult_seq_sched8 #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   p,
  output logic             busy,
  output logic [W/2-1:0]   mul_a,
  output logic [W/2-1:0]   mul_b,
  input  logic [W-1:0]     mul_p
);

  localparam int H = W / 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [1:0]     step;
  logic [2*W-1:0] acc;
  logic [W-1:0]   ra;
  logic [W-1:0]   rb;
  logic [2*W-1:0] pp;
  logic [2*W-1:0] addend;

  assign pp = {{W{1'b0}}, mul_p};

  // Core operands stay at zero outside RUN so the external core does not toggle.
  always_comb begin
    mul_a  = '0;
    mul_b  = '0;
    addend = '0;
    if (state == RUN) begin
      case (step)
        2'd0: begin
          mul_a  = ra[H-1:0];
          mul_b  = rb[H-1:0];
          addend = pp;
        end
        2'd1: begin
          mul_a  = ra[H-1:0];
          mul_b  = rb[W-1:H];
          addend = pp << H;
        end
        2'd2: begin
          mul_a  = ra[W-1:H];
          mul_b  = rb[H-1:0];
          addend = pp << H;
        end
        default: begin
          mul_a  = ra[W-1:H];
          mul_b  = rb[W-1:H];
          addend = pp << W;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 2'd0;
      acc   <= '0;
      ra    <= '0;
      rb    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra    <= a;
            rb    <= b;
            acc   <= '0;
            step  <= 2'd0;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc + addend;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // acc is left untouched after DONE, so p keeps showing the last result.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign p         = acc;

endmodule

// File: tb/tb_mult_seq_sched8.sv
// Directed and randomized checks of mult_seq_sched8 against a behavioural 4x4 core
// and hand-computed products.
module tb_mult_seq_sched8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  assign mul_p = {4'b0, mul_a} * {4'b0, mul_b};

  mult_seq_sched8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p)
  );

  // Handshake exclusivity is watched on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (!(in_ready === 1'b1 && out_valid === 1'b1)) else begin
        errors++;
        $error("[TB] FAIL ready_valid_overlap observed=%b%b expected=not 11", in_ready, out_valid);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] av, input logic [7:0] bv);
    in_valid = valid;
    a        = av;
    b        = bv;
  endtask

  // One full transaction: accept, fixed latency, optional stall, then drain.
  task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv, input int stall);
    int n;
    logic [15:0] expected;
    expected  = {8'b0, av} * {8'b0, bv};
    out_ready = 1'b0;
    applyStimulus(1'b1, av, bv);
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_accept"}, 32'(in_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 8'($urandom), 8'($urandom));
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'd4);
    repeat (stall) tick();
    checkOutput({tag, "_p"}, 32'(p), 32'(expected));
    out_ready = 1'b1;
    tick();
    checkOutput({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] av;
    logic [7:0] bv;
    int first_cyc;
    int n;

    rst_n     = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00);
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_p", 32'(p), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mul", 32'({mul_a, mul_b}), 32'd0);

    $display("[TB] basic 0x12*0x34");
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h12, 8'h34);
    tick();
    applyStimulus(1'b0, 8'hEE, 8'hDD);
    checkOutput("basic_busy", 32'(busy), 32'd1);
    checkOutput("basic_in_ready", 32'(in_ready), 32'd0);
    checkOutput("basic_step0", 32'({mul_a, mul_b}), 32'h24);
    tick();
    checkOutput("basic_step1", 32'({mul_a, mul_b}), 32'h23);
    tick();
    checkOutput("basic_step2", 32'({mul_a, mul_b}), 32'h14);
    tick();
    checkOutput("basic_step3", 32'({mul_a, mul_b}), 32'h13);
    checkOutput("basic_not_yet", 32'(out_valid), 32'd0);
    tick();
    checkOutput("basic_out_valid", 32'(out_valid), 32'd1);
    checkOutput("basic_p", 32'(p), 32'h03A8);
    checkOutput("basic_done_mul", 32'({mul_a, mul_b}), 32'd0);
    tick();
    checkOutput("basic_idle", 32'(in_ready), 32'd1);
    checkOutput("basic_p_hold", 32'(p), 32'h03A8);

    $display("[TB] max and zero operands");
    do_op("max", 8'hFF, 8'hFF, 0);
    do_op("zero", 8'h00, 8'hB7, 2);

    $display("[TB] backpressure 0x0F*0xF0");
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h0F, 8'hF0);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00);
    repeat (4) tick();
    applyStimulus(1'b1, 8'h01, 8'h01);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_p", 32'(p), 32'h0E10);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 8'h00);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_release_busy", 32'(busy), 32'd0);
    checkOutput("bp_release_p", 32'(p), 32'h0E10);

    $display("[TB] back-to-back");
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h03, 8'h05);
    tick();
    applyStimulus(1'b1, 8'h80, 8'h02);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    first_cyc = cyc;
    checkOutput("b2b_first_p", 32'(p), 32'h000F);
    tick();
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    applyStimulus(1'b0, 8'h00, 8'h00);
    checkOutput("b2b_second_p", 32'(p), 32'h0100);
    checkOutput("b2b_spacing", 32'(cyc - first_cyc), 32'd6);
    tick();

    $display("[TB] reset mid-operation");
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'hAA, 8'h55);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_p", 32'(p), 32'd0);
    checkOutput("midrst_mul", 32'({mul_a, mul_b}), 32'd0);
    repeat (6) begin
      tick();
      checkOutput("midrst_hold", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    do_op("after_rst", 8'h07, 8'h09, 0);
    checkOutput("after_rst_p", 32'(p), 32'h003F);

    $display("[TB] randomized operands");
    for (int i = 0; i < 1000; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      do_op("rand", av, bv, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_sched8.md
Name: mult_seq_sched8

Overview:
- Iterative 8x8 unsigned multiplier controller.
- Time-shares one external 4x4 combinational multiplier core (the 2x2-composed mult4 family) across four cycles, one partial product per cycle.
- Accumulates the shifted partial products into a 16-bit result.
- Sits between a valid/ready operand source and a valid/ready result sink, so the 8-bit design reuses a single 4-bit core instead of four.

Parameters:
- W, 8, operand width; must be even and >= 4.
- H, W/2, half width. Derived; must not be overridden; equals the core operand width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  W  multiplicand, unsigned.
- b  in  W  multiplier, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- p  out  2W  product a*b.
- busy  out  1  high in any state other than IDLE.
- mul_a  out  H  operand A to the external core.
- mul_b  out  H  operand B to the external core.
- mul_p  in  2H  product from the external core. Purely combinational from mul_a/mul_b, same cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, step=0, acc=0, operand latches=0.
  - in_ready=1 after reset release; out_valid=0, p=0, busy=0, mul_a=0, mul_b=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a->ra, b->rb; acc<=0; step<=0; go to RUN.
  - In any other state, in_valid is ignored and a/b are not sampled.
- RUN:
  - in_ready=0.
  - mul_a/mul_b are driven combinationally from step:
    - step0: ra[H-1:0], rb[H-1:0], shift 0
    - step1: ra[H-1:0], rb[W-1:H], shift H
    - step2: ra[W-1:H], rb[H-1:0], shift H
    - step3: ra[W-1:H], rb[W-1:H], shift W
  - Each edge: acc <= acc + (zero-extend mul_p to 2W) << shift; step <= step+1.
  - acc is 2W bits and must never overflow, since the max product is (2^W-1)^2.
  - On the edge that processes step3: go to DONE, step wraps to 0.
- DONE:
  - out_valid=1; p=acc, held stable.
  - Stays in DONE until out_ready=1 at an edge, then goes to IDLE.
  - in_ready=0 in DONE; no overlap between result hold and the next accept.
- Outside RUN: mul_a=0 and mul_b=0, to avoid core toggling.
- p holds the last result after DONE exits; p is valid only while out_valid=1.
- Latency: out_valid first high in the cycle following the 4th RUN edge, i.e. 4 edges after the accept edge.
- Throughput: minimum 6 cycles per operation, with out_ready tied high (accept, 4 RUN, DONE).
- Backpressure: out_ready low holds DONE indefinitely. p and out_valid stay stable; no new operand is accepted.
- Operand changes on a/b after acceptance have no effect on the in-flight result.
- rst_n asserted mid-RUN or mid-DONE: immediate return to reset values. The partial result is discarded and no out_valid pulse is emitted.
- out_valid and in_ready are never high in the same cycle.
- There are no X outputs after reset.

Test Plan:
- Basic: reset, then a=0x12, b=0x34 with in_valid and out_ready=1 → out_valid rises 4 edges after accept with p=0x03A8. Bench checks mul_a/mul_b per step: (2,4), (2,3), (1,4), (1,3).
- Max operands: a=0xFF, b=0xFF → p=0xFE01, no overflow. Also a=0x00, b=0xB7 → p=0x0000.
- Backpressure: a=0x0F, b=0xF0 with out_ready held low 10 cycles → out_valid stays 1, p stays 0x0E10, in_ready stays 0. A second in_valid during this window is not accepted. out_ready=1 → IDLE next cycle.
- Back-to-back: continuous in_valid with (0x03,0x05) then (0x80,0x02), out_ready=1 → results 0x000F then 0x0100, in order, 6 cycles apart.
- Reset mid-op: accept 0xAA*0x55, assert rst_n low after 2 RUN edges → outputs immediately at reset values, no out_valid. After release, 0x07*0x09 yields p=0x003F.
- Randomized: 1000 random a/b pairs with random out_ready stalls → every p equals a*b, against a bench model of the 4x4 core.
